// File: rtl/i2c_target_regs.sv
// i2c_target_regs: open-drain I2C target exposing NUM_REGS 8-bit registers (pointer write, data write/read).
// Define I2C_TGT_GENERAL_CALL_EN to ACK general call (8'h00) and write its data byte to reg 0.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'b0111110,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_drive_low,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_strobe,
    output logic [3:0]            wr_index,
    output logic                  busy
);
`ifdef I2C_TGT_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_scl_sync, r_sda_sync;
    logic                    r_scl_d, r_sda_d;
    logic [2:0]              r_bit, w_bit_nxt;
    logic [6:0]              r_shift, w_shift_nxt;
    logic [6:0]              r_tx, w_tx_nxt;
    logic [3:0]              r_ptr, w_ptr_nxt;
    logic                    r_drv, w_drv_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_rw, w_rw_nxt;
    logic                    r_gc, w_gc_nxt;
    logic                    r_wr_strobe;
    logic [3:0]              r_wr_index;
    logic [8*NUM_REGS-1:0]   r_regs;
    logic                    w_we, w_load;
    logic [3:0]              w_widx;

    wire        w_scl     = r_scl_sync[SYNC_STAGES-1];
    wire        w_sda     = r_sda_sync[SYNC_STAGES-1];
    wire        w_rise    = w_scl & ~r_scl_d;
    wire        w_fall    = ~w_scl & r_scl_d;
    wire        w_start   = w_scl & r_scl_d & r_sda_d & ~w_sda;
    wire        w_stop    = w_scl & r_scl_d & ~r_sda_d & w_sda;
    wire        w_last    = (r_bit == 3'd7);
    wire [7:0]  w_byte    = {r_shift, w_sda};
    wire        w_gc_hit  = GC_EN && (w_byte == 8'h00);
    wire [7:0]  w_rdata   = r_regs[8*r_ptr +: 8];
    wire [3:0]  w_ptr_inc = (r_ptr == 4'(NUM_REGS-1)) ? 4'd0 : r_ptr + 4'd1;

    assign sda_drive_low = r_drv;
    assign reg_q         = r_regs;
    assign wr_strobe     = r_wr_strobe;
    assign wr_index      = r_wr_index;
    assign busy          = r_busy;

    // Synchronizers reset to the idle-bus level so reset release never fakes an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_ptr       <= '0;
            r_drv       <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_gc        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
            r_regs      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_drv       <= w_drv_nxt;
            r_busy      <= w_busy_nxt;
            r_rw        <= w_rw_nxt;
            r_gc        <= w_gc_nxt;
            r_wr_strobe <= w_we;
            r_wr_index  <= w_we ? w_widx : r_wr_index;
            if (w_we)
                r_regs[8*w_widx +: 8] <= w_byte;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_ptr_nxt   = r_ptr;
        w_drv_nxt   = r_drv;
        w_busy_nxt  = r_busy;
        w_rw_nxt    = r_rw;
        w_gc_nxt    = r_gc;
        w_we        = 1'b0;
        w_load      = 1'b0;
        w_widx      = r_gc ? 4'd0 : r_ptr;
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_drv_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ADDR;
            w_bit_nxt   = '0;
            w_drv_nxt   = 1'b0;
            w_gc_nxt    = 1'b0;
        end else begin
            if (w_rise && (r_state inside {ADDR, PTR, WDATA})) begin
                w_shift_nxt = w_byte[6:0];
                w_bit_nxt   = r_bit + 3'd1;
            end
            case (r_state)
                ADDR: if (w_rise && w_last) begin
                    w_rw_nxt    = w_byte[0];
                    w_gc_nxt    = w_gc_hit;
                    w_state_nxt = (w_byte[7:1] == TARGET_ADDR || w_gc_hit) ? ADDR_ACK : IGNORE;
                    w_busy_nxt  = (w_byte[7:1] == TARGET_ADDR || w_gc_hit);
                end
                PTR: if (w_rise && w_last) begin
                    if (w_byte < 8'(NUM_REGS)) begin
                        w_ptr_nxt   = w_byte[3:0];
                        w_state_nxt = PTR_ACK;
                    end else begin
                        w_state_nxt = IGNORE;
                        w_busy_nxt  = 1'b0;
                    end
                end
                WDATA: if (w_rise && w_last) begin
                    w_we        = 1'b1;
                    w_ptr_nxt   = r_gc ? r_ptr : w_ptr_inc;
                    w_state_nxt = WDATA_ACK;
                end
                // First fall pulls SDA low for the ACK, second fall releases it
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_fall) begin
                    w_drv_nxt = ~r_drv;
                    w_bit_nxt = '0;
                    if (r_drv && r_state == ADDR_ACK && r_rw) begin
                        w_load = 1'b1;
                    end else if (r_drv && r_state == WDATA_ACK && r_gc) begin
                        w_state_nxt = IGNORE;
                        w_busy_nxt  = 1'b0;
                    end else if (r_drv) begin
                        w_state_nxt = (r_state == ADDR_ACK && !r_gc) ? PTR : WDATA;
                    end
                end
                RDATA: if (w_fall) begin
                    w_drv_nxt   = w_last ? 1'b0 : ~r_tx[6];
                    w_tx_nxt    = {r_tx[5:0], 1'b0};
                    w_bit_nxt   = r_bit + 3'd1;
                    w_state_nxt = w_last ? RDATA_ACK : RDATA;
                end
                RDATA_ACK: begin
                    if (w_rise && w_sda) begin
                        w_state_nxt = IGNORE;
                        w_busy_nxt  = 1'b0;
                    end else if (w_fall) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_load) begin
                w_state_nxt = RDATA;
                w_tx_nxt    = w_rdata[6:0];
                w_drv_nxt   = ~w_rdata[7];
                w_ptr_nxt   = w_ptr_inc;
                w_bit_nxt   = '0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-level I2C master model with ACK/read/write scoreboards against a register model.
module tb_i2c_target_regs;
    localparam int NR = 4;

    logic          clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic          sda_drive_low, wr_strobe, busy, sda_line;
    logic [8*NR-1:0] reg_q;
    logic [3:0]    wr_index;
    int            n_vec = 0, n_miss = 0;
    logic [7:0]    model [NR];
    logic          ack_q [$];
    logic [7:0]    rd_q [$];
    logic [3:0]    wr_q [$], obs_wr [$];

    assign sda_line = sda_m & ~sda_drive_low;
    always #5 clk = ~clk;

    i2c_target_regs #(.TARGET_ADDR(7'b0111110), .NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
        .sda_drive_low(sda_drive_low), .reg_q(reg_q), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    always @(negedge clk) if (wr_strobe === 1'b1) obs_wr.push_back(wr_index);

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    function automatic logic [8*NR-1:0] model_flat();
        logic [8*NR-1:0] f;
        for (int k = 0; k < NR; k++) f[8*k +: 8] = model[k];
        return f;
    endfunction

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic b, output logic r);
        wclk(5); sda_m = b; wclk(5); scl = 1'b1; wclk(5); r = sda_line; wclk(5); scl = 1'b0;
    endtask

    task automatic start_c;
        wclk(5); sda_m = 1'b1; wclk(5); scl = 1'b1; wclk(5); sda_m = 1'b0; wclk(5); scl = 1'b0;
    endtask

    task automatic stop_c;
        wclk(5); sda_m = 1'b0; wclk(5); scl = 1'b1; wclk(5); sda_m = 1'b1; wclk(5);
    endtask

    task automatic put_byte(input logic [7:0] b, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) xfer(b[i], r);
        xfer(1'b1, a);
    endtask

    task automatic get_byte(input logic ack_bit, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) xfer(1'b1, d[i]);
        xfer(ack_bit, r);
    endtask

    task automatic test_reset;
        logic r;
        n_vec++; if (sda_drive_low !== 1'b0) begin n_miss++; $display("FAIL rst_sda: got %b want 0", sda_drive_low); end
        n_vec++; if (reg_q !== '0) begin n_miss++; $display("FAIL rst_regs: got %h want 0", reg_q); end
        n_vec++; if (wr_strobe !== 1'b0) begin n_miss++; $display("FAIL rst_strobe: got %b want 0", wr_strobe); end
        n_vec++; if (wr_index !== 4'd0) begin n_miss++; $display("FAIL rst_index: got %h want 0", wr_index); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy: got %b want 0", busy); end
        start_c;
        for (int i = 7; i >= 0; i--) xfer(logic'(8'h7C >> i), r);
        wclk(6);
        n_vec++; if (sda_drive_low !== 1'b1) begin n_miss++; $display("FAIL ack_drive: got %b want 1", sda_drive_low); end
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL ack_busy: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (sda_drive_low !== 1'b0) begin n_miss++; $display("FAIL async_release: got %b want 0", sda_drive_low); end
        wclk(1);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst2_busy: got %b want 0", busy); end
        n_vec++; if (reg_q !== '0) begin n_miss++; $display("FAIL rst2_regs: got %h want 0", reg_q); end
        scl = 1'b1; sda_m = 1'b1;
        wclk(4); reset = 1'b0; wclk(10);
    endtask

    task automatic test_write_single;
        logic [7:0] tx [3] = '{8'h7C, 8'h01, 8'hA5};
        logic a, e;
        wr_q.push_back(4'd1); model[1] = 8'hA5;
        start_c;
        foreach (tx[i]) begin
            ack_q.push_back(1'b0); put_byte(tx[i], a); e = ack_q.pop_front();
            n_vec++; if (a !== e) begin n_miss++; $display("FAIL ws_ack %h: got %b want %b", tx[i], a, e); end
        end
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL ws_busy: got %b want 1", busy); end
        stop_c; wclk(5);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL ws_busy_stop: got %b want 0", busy); end
        n_vec++; if (obs_wr.size() != wr_q.size()) begin n_miss++; $display("FAIL ws_wr_count: got %0d want %0d", obs_wr.size(), wr_q.size()); end
        while (wr_q.size() > 0 && obs_wr.size() > 0) begin
            logic [3:0] o = obs_wr.pop_front(), x = wr_q.pop_front();
            n_vec++; if (o !== x) begin n_miss++; $display("FAIL ws_wr_index: got %0d want %0d", o, x); end
        end
        wr_q.delete(); obs_wr.delete();
        n_vec++; if (reg_q !== model_flat()) begin n_miss++; $display("FAIL ws_regs: got %h want %h", reg_q, model_flat()); end
    endtask

    task automatic test_wrap;
        logic [7:0] tx [4] = '{8'h7C, 8'h03, 8'h11, 8'h22};
        logic a, e;
        wr_q.push_back(4'd3); wr_q.push_back(4'd0); model[3] = 8'h11; model[0] = 8'h22;
        start_c;
        foreach (tx[i]) begin
            ack_q.push_back(1'b0); put_byte(tx[i], a); e = ack_q.pop_front();
            n_vec++; if (a !== e) begin n_miss++; $display("FAIL wrap_ack %h: got %b want %b", tx[i], a, e); end
        end
        stop_c; wclk(5);
        n_vec++; if (obs_wr.size() != wr_q.size()) begin n_miss++; $display("FAIL wrap_wr_count: got %0d want %0d", obs_wr.size(), wr_q.size()); end
        while (wr_q.size() > 0 && obs_wr.size() > 0) begin
            logic [3:0] o = obs_wr.pop_front(), x = wr_q.pop_front();
            n_vec++; if (o !== x) begin n_miss++; $display("FAIL wrap_wr_index: got %0d want %0d", o, x); end
        end
        wr_q.delete(); obs_wr.delete();
        n_vec++; if (reg_q !== model_flat()) begin n_miss++; $display("FAIL wrap_regs: got %h want %h", reg_q, model_flat()); end
    endtask

    task automatic test_read;
        logic [7:0] tx [4] = '{8'h7C, 8'h02, 8'h5A, 8'hC3};
        logic [7:0] d, x;
        logic a, e;
        wr_q.push_back(4'd2); wr_q.push_back(4'd3); model[2] = 8'h5A; model[3] = 8'hC3;
        start_c;
        foreach (tx[i]) begin
            ack_q.push_back(1'b0); put_byte(tx[i], a); e = ack_q.pop_front();
            n_vec++; if (a !== e) begin n_miss++; $display("FAIL rd_pre_ack %h: got %b want %b", tx[i], a, e); end
        end
        stop_c; wclk(5);
        n_vec++; if (obs_wr.size() != wr_q.size()) begin n_miss++; $display("FAIL rd_wr_count: got %0d want %0d", obs_wr.size(), wr_q.size()); end
        wr_q.delete(); obs_wr.delete();
        start_c;
        ack_q.push_back(1'b0); put_byte(8'h7C, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL rd_addr_ack: got %b want %b", a, e); end
        ack_q.push_back(1'b0); put_byte(8'h02, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL rd_ptr_ack: got %b want %b", a, e); end
        start_c;
        ack_q.push_back(1'b0); put_byte(8'h7D, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL rd_raddr_ack: got %b want %b", a, e); end
        rd_q.push_back(model[2]); get_byte(1'b0, d); x = rd_q.pop_front();
        n_vec++; if (d !== x) begin n_miss++; $display("FAIL rd_byte0: got %h want %h", d, x); end
        rd_q.push_back(model[3]); get_byte(1'b1, d); x = rd_q.pop_front();
        n_vec++; if (d !== x) begin n_miss++; $display("FAIL rd_byte1: got %h want %h", d, x); end
        wclk(5);
        n_vec++; if (sda_drive_low !== 1'b0) begin n_miss++; $display("FAIL rd_release: got %b want 0", sda_drive_low); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rd_busy_nack: got %b want 0", busy); end
        stop_c; wclk(5);
    endtask

    task automatic test_bad_ptr;
        logic [7:0] d, x;
        logic a, e;
        start_c;
        ack_q.push_back(1'b0); put_byte(8'h7C, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_addr_ack: got %b want %b", a, e); end
        ack_q.push_back(1'b0); put_byte(8'h01, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_ptr1_ack: got %b want %b", a, e); end
        stop_c;
        start_c;
        ack_q.push_back(1'b0); put_byte(8'h7C, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_addr2_ack: got %b want %b", a, e); end
        ack_q.push_back(1'b1); put_byte(8'h09, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_ptr9_nack: got %b want %b", a, e); end
        ack_q.push_back(1'b1); put_byte(8'h33, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_data_nack: got %b want %b", a, e); end
        stop_c; wclk(5);
        n_vec++; if (obs_wr.size() != 0) begin n_miss++; $display("FAIL bp_wr_count: got %0d want 0", obs_wr.size()); end
        obs_wr.delete();
        n_vec++; if (reg_q !== model_flat()) begin n_miss++; $display("FAIL bp_regs: got %h want %h", reg_q, model_flat()); end
        start_c;
        ack_q.push_back(1'b0); put_byte(8'h7D, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL bp_raddr_ack: got %b want %b", a, e); end
        rd_q.push_back(model[1]); get_byte(1'b1, d); x = rd_q.pop_front();
        n_vec++; if (d !== x) begin n_miss++; $display("FAIL bp_ptr_kept: got %h want %h", d, x); end
        stop_c;
        start_c;
        ack_q.push_back(1'b1); put_byte(8'h42, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL other_addr_nack: got %b want %b", a, e); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL other_addr_busy: got %b want 0", busy); end
        stop_c; wclk(5);
    endtask

    task automatic test_general_call;
        logic a, e;
`ifdef I2C_TGT_GENERAL_CALL_EN
        ack_q.push_back(1'b0); ack_q.push_back(1'b0);
        wr_q.push_back(4'd0); model[0] = 8'h77;
`else
        ack_q.push_back(1'b1); ack_q.push_back(1'b1);
`endif
        start_c;
        put_byte(8'h00, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL gc_addr_ack: got %b want %b", a, e); end
        put_byte(8'h77, a); e = ack_q.pop_front();
        n_vec++; if (a !== e) begin n_miss++; $display("FAIL gc_data_ack: got %b want %b", a, e); end
        stop_c; wclk(5);
        n_vec++; if (obs_wr.size() != wr_q.size()) begin n_miss++; $display("FAIL gc_wr_count: got %0d want %0d", obs_wr.size(), wr_q.size()); end
        while (wr_q.size() > 0 && obs_wr.size() > 0) begin
            logic [3:0] o = obs_wr.pop_front(), x = wr_q.pop_front();
            n_vec++; if (o !== x) begin n_miss++; $display("FAIL gc_wr_index: got %0d want %0d", o, x); end
        end
        wr_q.delete(); obs_wr.delete();
        n_vec++; if (reg_q !== model_flat()) begin n_miss++; $display("FAIL gc_regs: got %h want %h", reg_q, model_flat()); end
    endtask

    initial begin
        foreach (model[k]) model[k] = 8'h00;
        wclk(5);
        reset = 1'b0;
        wclk(10);
        test_reset;
        test_write_single;
        test_wrap;
        test_read;
        test_bad_ptr;
        test_general_call;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
